// File: rtl/sha256_msg_feeder.sv
// ---------------------------------------------------------------------------
// sha256_msg_feeder
//
// Initiator side of the sha256_core_v3 block interface. It takes a byte
// stream from the host, packs it big-endian into 512-bit blocks, and appends
// the FIPS 180-4 padding: one 0x80 byte, zero fill, then the 64-bit message
// bit length. For each block it drives the core start/first_run handshake.
// When the final block completes, it captures the digest the core returns.
//
// Parameters
//   LEN_W        width of the message bit-length counter (4..64). Length
//                field bits at and above LEN_W are sent as zero.
//
// Ports
//   clk          single clock, rising edge
//   rst_n        asynchronous active-low reset
//   s_valid      input beat valid
//   s_data[7:0]  message byte; the first byte of a block lands in [511:504]
//   s_last       final beat of the message
//   s_empty      qualifies s_last: the beat carries no byte
//   s_ready      beat accepted when s_valid & s_ready
//   core_start   core start request, held from SEND through BUSY
//   core_block   block to the core; stable while core_start is high
//   core_first   core first_run; high only for block 0 of a message
//   core_ready   core ready
//   core_hash    core hash output
//   digest       final digest, held until the next message starts
//   digest_valid level; set when the digest loads, cleared by the next
//                message's first beat
// ---------------------------------------------------------------------------
module sha256_msg_feeder #(
   parameter int LEN_W = 64
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         s_valid,
   input  logic [7:0]   s_data,
   input  logic         s_last,
   input  logic         s_empty,
   output logic         s_ready,
   output logic         core_start,
   output logic [511:0] core_block,
   output logic         core_first,
   input  logic         core_ready,
   input  logic [255:0] core_hash,
   output logic [255:0] digest,
   output logic         digest_valid
);

   typedef enum logic [2:0] {
      ST_FILL,
      ST_PAD,
      ST_LEN,
      ST_SEND,
      ST_ACK,
      ST_BUSY,
      ST_REL
   } state_t;

   state_t             state_q,  state_d;
   logic [5:0]         idx_q,    idx_d;
   logic [LEN_W-1:0]   bitlen_q, bitlen_d;
   logic [511:0]       block_q,  block_d;
   logic               first_q,  first_d;    // current block is block 0
   logic               final_q,  final_d;    // current block carries the length
   logic               pend80_q, pend80_d;   // 0x80 marker still to be written
   logic               pad_q,    pad_d;      // message data done, padding phase
   logic               in_msg_q, in_msg_d;   // at least one beat of a message taken
   logic               rdy_en_q, rdy_en_d;   // holds s_ready low for a cycle after reset
   logic               start_q,  start_d;
   logic               cfirst_q, cfirst_d;
   logic [255:0]       digest_q, digest_d;
   logic               dvalid_q, dvalid_d;

   logic               accept;
   logic [63:0]        len64;

   // Write one byte into the block at byte position idx (byte 0 = MSB).
   function automatic logic [511:0] put_byte(input logic [511:0] blk,
                                             input logic [5:0]   idx,
                                             input logic [7:0]   b);
      logic [511:0] r;
      logic [8:0]   off;
      r   = blk;
      off = 9'd504 - {idx, 3'b000};
      r[off +: 8] = b;
      return r;
   endfunction

   assign len64   = 64'(bitlen_q);
   assign s_ready = (state_q == ST_FILL) && rdy_en_q;
   assign accept  = s_valid && s_ready;

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      bitlen_d = bitlen_q;
      block_d  = block_q;
      first_d  = first_q;
      final_d  = final_q;
      pend80_d = pend80_q;
      pad_d    = pad_q;
      in_msg_d = in_msg_q;
      rdy_en_d = 1'b1;
      cfirst_d = cfirst_q;
      digest_d = digest_q;
      dvalid_d = dvalid_q;

      case (state_q)
         ST_FILL: begin
            if (accept) begin
               if (!in_msg_q) begin
                  // First beat of a new message.
                  in_msg_d = 1'b1;
                  first_d  = 1'b1;
                  dvalid_d = 1'b0;
               end
               if (s_last && s_empty) begin
                  // Empty tail: the marker takes the byte slot in this beat.
                  block_d = put_byte(block_q, idx_q, 8'h80);
                  idx_d   = idx_q + 6'd1;
                  pad_d   = 1'b1;
                  state_d = (idx_q == 6'd63) ? ST_SEND : ST_PAD;
               end else begin
                  block_d  = put_byte(block_q, idx_q, s_data);
                  idx_d    = idx_q + 6'd1;
                  bitlen_d = bitlen_q + LEN_W'(8);
                  if (s_last) begin
                     pad_d    = 1'b1;
                     pend80_d = 1'b1;
                  end
                  if (idx_q == 6'd63) begin
                     state_d = ST_SEND;
                  end else if (s_last) begin
                     state_d = ST_PAD;
                  end
               end
            end
         end

         ST_PAD: begin
            if (!pend80_q && idx_q == 6'd56) begin
               // Marker landed at 55: length slot already reached.
               state_d = ST_LEN;
            end else begin
               block_d  = put_byte(block_q, idx_q, pend80_q ? 8'h80 : 8'h00);
               pend80_d = 1'b0;
               idx_d    = idx_q + 6'd1;
               if (idx_q == 6'd63) begin
                  // No room for the length: ship this block, pad a fresh one.
                  state_d = ST_SEND;
               end else if (idx_q == 6'd55) begin
                  state_d = ST_LEN;
               end
            end
         end

         ST_LEN: begin
            block_d[63:0] = len64;
            final_d       = 1'b1;
            idx_d         = 6'd0;
            state_d       = ST_SEND;
         end

         ST_SEND: begin
            state_d = ST_ACK;
         end

         ST_ACK: begin
            if (!core_ready) begin
               state_d = ST_BUSY;
            end
         end

         ST_BUSY: begin
            if (core_ready) begin
               state_d = ST_REL;
               if (final_q) begin
                  digest_d = core_hash;
                  dvalid_d = 1'b1;
               end
            end
         end

         ST_REL: begin
            first_d = 1'b0;
            block_d = '0;
            if (final_q) begin
               final_d  = 1'b0;
               in_msg_d = 1'b0;
               pad_d    = 1'b0;
               pend80_d = 1'b0;
               idx_d    = 6'd0;
               bitlen_d = '0;
               state_d  = ST_FILL;
            end else if (pad_q) begin
               state_d = ST_PAD;
            end else begin
               state_d = ST_FILL;
            end
         end

         default: begin
            state_d = ST_FILL;
         end
      endcase

      // Start is asserted from SEND through BUSY; first_run is sampled once
      // on entry to SEND so it stays put for the whole handshake.
      start_d = (state_d == ST_SEND) || (state_d == ST_ACK) || (state_d == ST_BUSY);
      if (state_d == ST_SEND && state_q != ST_SEND) begin
         cfirst_d = first_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_FILL;
         idx_q    <= '0;
         bitlen_q <= '0;
         block_q  <= '0;
         first_q  <= 1'b0;
         final_q  <= 1'b0;
         pend80_q <= 1'b0;
         pad_q    <= 1'b0;
         in_msg_q <= 1'b0;
         rdy_en_q <= 1'b0;
         start_q  <= 1'b0;
         cfirst_q <= 1'b0;
         digest_q <= '0;
         dvalid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         bitlen_q <= bitlen_d;
         block_q  <= block_d;
         first_q  <= first_d;
         final_q  <= final_d;
         pend80_q <= pend80_d;
         pad_q    <= pad_d;
         in_msg_q <= in_msg_d;
         rdy_en_q <= rdy_en_d;
         start_q  <= start_d;
         cfirst_q <= cfirst_d;
         digest_q <= digest_d;
         dvalid_q <= dvalid_d;
      end
   end

   assign core_start   = start_q;
   assign core_block   = block_q;
   assign core_first   = cfirst_q;
   assign digest       = digest_q;
   assign digest_valid = dvalid_q;

endmodule

// File: tb/tb_sha256_msg_feeder.sv
// ---------------------------------------------------------------------------
// tb_sha256_msg_feeder
//
// Bench for sha256_msg_feeder. The core is a behavioural model that runs a
// real SHA-256 compression on each block it receives. The stimulus process
// queues the expected blocks and digests. A monitor process compares them
// when the DUT raises core_start or digest_valid. Point checks such as reset
// values are handed to the monitor through a request queue.
// ---------------------------------------------------------------------------
module tb_sha256_msg_feeder;

   logic         clk;
   logic         rst_n;
   logic         s_valid;
   logic [7:0]   s_data;
   logic         s_last;
   logic         s_empty;
   logic         s_ready;
   logic         core_start;
   logic [511:0] core_block;
   logic         core_first;
   logic         core_ready;
   logic [255:0] core_hash;
   logic [255:0] digest;
   logic         digest_valid;

   sha256_msg_feeder #(.LEN_W(64)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .s_valid      (s_valid),
      .s_data       (s_data),
      .s_last       (s_last),
      .s_empty      (s_empty),
      .s_ready      (s_ready),
      .core_start   (core_start),
      .core_block   (core_block),
      .core_first   (core_first),
      .core_ready   (core_ready),
      .core_hash    (core_hash),
      .digest       (digest),
      .digest_valid (digest_valid)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- SHA-256 reference compression for the core model -----
   localparam logic [31:0] K [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };
   localparam logic [255:0] H0 =
      256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

   function automatic logic [31:0] ror(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [255:0] sha_comp(input logic [255:0] hin, input logic [511:0] blk);
      logic [31:0] w [0:63];
      logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
      for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
      for (int t = 16; t < 64; t++)
         w[t] = (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
              + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
      {a, b, c, d, e, f, g, h} = hin;
      for (int t = 0; t < 64; t++) begin
         t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
         t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
         h = g; g = f; f = e; e = d + t1;
         d = c; c = b; b = a; a = t1 + t2;
      end
      return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
              hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
   endfunction

   // ---------------- core model ----------------
   logic [1:0]   cm_st;
   logic [3:0]   cm_cnt;
   logic [255:0] cm_chain;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cm_st      <= 2'd0;
         cm_cnt     <= 4'd0;
         cm_chain   <= '0;
         core_ready <= 1'b1;
         core_hash  <= '0;
      end else begin
         case (cm_st)
            2'd0: if (core_start) begin
               cm_st      <= 2'd1;
               core_ready <= 1'b0;
               cm_chain   <= sha_comp(core_first ? H0 : cm_chain, core_block);
               cm_cnt     <= 4'd5;
            end
            2'd1: if (cm_cnt == 4'd0) begin
               core_ready <= 1'b1;
               core_hash  <= cm_chain;
               cm_st      <= 2'd2;
            end else begin
               cm_cnt <= cm_cnt - 4'd1;
            end
            default: if (!core_start) cm_st <= 2'd0;
         endcase
      end
   end

   // ---------------- scoreboard ----------------
   typedef struct packed {
      logic         first;
      logic [511:0] blk;
   } blk_exp_t;

   typedef struct packed {
      logic         chk;
      logic [255:0] val;
   } dig_exp_t;

   localparam int REQ_RST = 0, REQ_RDY = 1, REQ_DV0 = 2, REQ_TO = 3, REQ_END = 4;

   blk_exp_t blk_q [$];
   dig_exp_t dig_q [$];
   int       req_q [$];

   int checks;
   int errors;

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", name, act, exp);
      end
   endtask

   task automatic flag_fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s got event want none", name);
   endtask

   initial begin : monitor
      logic         prev_start;
      logic         prev_dv;
      logic [511:0] cur_blk;
      logic         cur_first;
      blk_exp_t     be;
      dig_exp_t     de;
      int           r;
      checks     = 0;
      errors     = 0;
      prev_start = 1'b0;
      prev_dv    = 1'b0;
      cur_blk    = '0;
      cur_first  = 1'b0;
      forever begin
         @(negedge clk);
         if (core_start && !prev_start) begin
            if (blk_q.size() == 0) begin
               flag_fail("unexpected_block");
            end else begin
               be        = blk_q.pop_front();
               cur_blk   = be.blk;
               cur_first = be.first;
               check("block", core_block, cur_blk);
               check("core_first", 512'(core_first), 512'(cur_first));
            end
         end else if (core_start && prev_start) begin
            check("block_hold", core_block, cur_blk);
            check("first_hold", 512'(core_first), 512'(cur_first));
         end
         if (digest_valid && !prev_dv) begin
            if (dig_q.size() == 0) begin
               flag_fail("unexpected_digest");
            end else begin
               de = dig_q.pop_front();
               if (de.chk) check("digest", 512'(digest), 512'(de.val));
            end
         end
         prev_start = core_start;
         prev_dv    = digest_valid;
         if (req_q.size() > 0) begin
            r = req_q.pop_front();
            case (r)
               REQ_RST: begin
                  check("rst_s_ready", 512'(s_ready), 512'(0));
                  check("rst_core_start", 512'(core_start), 512'(0));
                  check("rst_core_first", 512'(core_first), 512'(0));
                  check("rst_core_block", core_block, 512'(0));
                  check("rst_digest", 512'(digest), 512'(0));
                  check("rst_digest_valid", 512'(digest_valid), 512'(0));
               end
               REQ_RDY: check("s_ready_up", 512'(s_ready), 512'(1));
               REQ_DV0: check("dv_clear_first_beat", 512'(digest_valid), 512'(0));
               REQ_TO:  flag_fail("timeout");
               default: begin
                  check("queues_drained", 512'(blk_q.size() + dig_q.size()), 512'(0));
                  $display("CHECKS %0d ERRORS %0d", checks, errors);
                  $finish;
               end
            endcase
         end
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog got no finish want finish");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_seq();
      rst_n = 1'b0;
      step();
      req_q.push_back(REQ_RST);
      step();
      rst_n = 1'b1;
      req_q.push_back(REQ_RST);
      step();
      req_q.push_back(REQ_RDY);
      step();
   endtask

   task automatic send_beat(input logic [7:0] d, input logic last, input logic empty, input logic gap);
      int n;
      s_valid = 1'b1;
      s_data  = d;
      s_last  = last;
      s_empty = empty;
      for (n = 0; n < 500; n++) begin
         @(negedge clk);
         if (s_ready) break;
      end
      if (n == 500) req_q.push_back(REQ_TO);
      step();
      s_valid = 1'b0;
      s_last  = 1'b0;
      s_empty = 1'b0;
      if (gap) step();
   endtask

   task automatic wait_dv();
      int n;
      for (n = 0; n < 2000; n++) begin
         @(negedge clk);
         if (digest_valid) break;
      end
      if (n == 2000) req_q.push_back(REQ_TO);
      step();
   endtask

   task automatic send_abc(input logic gap);
      send_beat(8'h61, 1'b0, 1'b0, gap);
      req_q.push_back(REQ_DV0);
      send_beat(8'h62, 1'b0, 1'b0, gap);
      send_beat(8'h63, 1'b1, 1'b0, gap);
   endtask

   localparam logic [255:0] D_EMPTY =
      256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
   localparam logic [255:0] D_ABC =
      256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [255:0] D_56 =
      256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
   localparam logic [511:0] B_ABC = {32'h61626380, 416'h0, 64'h18};

   initial begin : stim
      logic [447:0] m3;
      int           n;
      s_valid = 1'b0;
      s_data  = 8'h00;
      s_last  = 1'b0;
      s_empty = 1'b0;
      rst_n   = 1'b0;
      m3 = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
      step();
      reset_seq();

      // 1: empty message
      blk_q.push_back('{1'b1, {8'h80, 504'h0}});
      dig_q.push_back('{1'b1, D_EMPTY});
      send_beat(8'h00, 1'b1, 1'b1, 1'b0);
      wait_dv();

      // 2: "abc"
      blk_q.push_back('{1'b1, B_ABC});
      dig_q.push_back('{1'b1, D_ABC});
      send_abc(1'b0);
      wait_dv();

      // 3: 56-byte message, two blocks
      blk_q.push_back('{1'b1, {m3, 8'h80, 56'h0}});
      blk_q.push_back('{1'b0, {448'h0, 64'h1c0}});
      dig_q.push_back('{1'b1, D_56});
      for (int i = 0; i < 56; i++) send_beat(m3[447 - 8*i -: 8], i == 55, 1'b0, 1'b0);
      wait_dv();

      // 4: 64 x 'a', second block is marker + pad + length only
      blk_q.push_back('{1'b1, {64{8'h61}}});
      blk_q.push_back('{1'b0, {8'h80, 440'h0, 64'h200}});
      dig_q.push_back('{1'b0, 256'h0});
      for (int i = 0; i < 64; i++) send_beat(8'h61, i == 63, 1'b0, 1'b0);
      wait_dv();

      // 5: "abc" with s_valid toggling
      blk_q.push_back('{1'b1, B_ABC});
      dig_q.push_back('{1'b1, D_ABC});
      send_abc(1'b1);
      wait_dv();

      // 6: reset while the core is busy, then "abc" again
      blk_q.push_back('{1'b1, B_ABC});
      send_abc(1'b0);
      for (n = 0; n < 2000; n++) begin
         @(negedge clk);
         if (core_start && !core_ready) break;
      end
      if (n == 2000) req_q.push_back(REQ_TO);
      step();
      reset_seq();
      blk_q.push_back('{1'b1, B_ABC});
      dig_q.push_back('{1'b1, D_ABC});
      send_abc(1'b0);
      wait_dv();

      req_q.push_back(REQ_END);
      repeat (5) step();
      $display("FAIL end_request got unserviced want serviced");
      $fatal(1, "end not reached");
   end

endmodule
